// File: rtl/mm_sched.sv
// mm_sched: sequencing controller for the MAX_DIM x MAX_DIM systolic MAC array.
// Latency: FEED starts the cycle after accept; done_o comes 3n-2+PE_LAT cycles later.
// Backpressure: none; start_i is ignored while busy and nothing is queued.
//
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/abort_i/dim_i/mode_i
// are job control; ovf_i carries the per-PE overflow flags. busy_o, pe_start_o and
// mode_o drive the array. a_/b_ rd_en/k carry the skewed feeder strobes and indices.
// res_capture_o, done_o, err_o and ovf_o report job status.
// Optional: define MM_SCHED_PERF_EN to add the perf_jobs_o/perf_busy_o counters.
module mm_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = 4,
  parameter int PE_LAT     = 3,
  parameter int IDXW       = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  parameter int TW         = $clog2(3*MAX_DIM+PE_LAT)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [IDXW:0]                dim_i,
  input  logic                         mode_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]   ovf_i,
  output logic                         busy_o,
  output logic                         pe_start_o,
  output logic                         mode_o,
  output logic [MAX_DIM-1:0]           a_rd_en_o,
  output logic [MAX_DIM*IDXW-1:0]      a_k_o,
  output logic [MAX_DIM-1:0]           b_rd_en_o,
  output logic [MAX_DIM*IDXW-1:0]      b_k_o,
  output logic                         res_capture_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         ovf_o
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_jobs_o,
  output logic [31:0]                  perf_busy_o
`endif
);

  // The feeders are sized from DATA_WIDTH; the array accumulates in BUS_WIDTH.
  if (DATA_WIDTH < 1 || BUS_WIDTH < DATA_WIDTH) begin : g_bad_cfg
    $error("mm_sched: BUS_WIDTH must be at least DATA_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [IDXW:0]       n_q, n_d;
  logic                mode_q, mode_d;
  logic                dim_ok, accept, err_d, kill;
  logic [TW-1:0]       n_t, feed_last, cap_t;
  logic [MAX_DIM-1:0]  en_d;
  logic [MAX_DIM*IDXW-1:0] k_d;
  logic                ovf_any;

  assign dim_ok = (dim_i != '0) && (int'(dim_i) <= MAX_DIM);

  // Phase boundaries of the job being (or about to be) run.
  assign n_t       = TW'(n_d);
  assign feed_last = (n_t << 1) - TW'(2);
  assign cap_t     = n_t * TW'(3) - TW'(3) + TW'(PE_LAT);

  // Abort only cancels a job that is still feeding or draining.
  assign kill = abort_i && (state_q == S_FEED || state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start_i && !abort_i) begin
          if (dim_ok) begin
            accept  = 1'b1;
            state_d = S_FEED;
            n_d     = dim_i;
            mode_d  = mode_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        t_d = t_q + TW'(1);
        if (t_q == feed_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        t_d = t_q + TW'(1);
        if (t_q == cap_t) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
    if (kill) begin
      state_d = S_IDLE;
      t_d     = '0;
    end
  end

  // Row/column i is fed during t = i .. i+n-1 with index t-i; A and B share the rule.
  always_comb begin
    en_d = '0;
    k_d  = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (state_d == S_FEED && i < int'(n_d) &&
          int'(t_d) >= i && int'(t_d) < i + int'(n_d)) begin
        en_d[i]              = 1'b1;
        k_d[i*IDXW +: IDXW]  = IDXW'(int'(t_d) - i);
      end
    end
  end

  // Only PEs inside the active n x n corner contribute to the overflow summary.
  always_comb begin
    ovf_any = 1'b0;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        if (i < int'(n_q) && j < int'(n_q)) ovf_any = ovf_any | ovf_i[i*MAX_DIM+j];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      t_q           <= '0;
      n_q           <= '0;
      mode_q        <= 1'b0;
      busy_o        <= 1'b0;
      pe_start_o    <= 1'b0;
      mode_o        <= 1'b0;
      a_rd_en_o     <= '0;
      a_k_o         <= '0;
      b_rd_en_o     <= '0;
      b_k_o         <= '0;
      res_capture_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      n_q           <= n_d;
      mode_q        <= mode_d;
      // Outputs are registered from the next state so they line up with t.
      busy_o        <= (state_d != S_IDLE);
      pe_start_o    <= (state_d == S_FEED) || (state_d == S_DRAIN);
      mode_o        <= (state_d != S_IDLE) ? mode_d : 1'b0;
      a_rd_en_o     <= en_d;
      a_k_o         <= k_d;
      b_rd_en_o     <= en_d;
      b_k_o         <= k_d;
      res_capture_o <= (state_d == S_DRAIN) && (t_d == cap_t);
      done_o        <= (state_d == S_DONE);
      err_o         <= err_d;
      // res_capture_o high marks the capture cycle itself.
      if (accept || kill)     ovf_o <= 1'b0;
      else if (res_capture_o) ovf_o <= ovf_any;
    end
  end

`ifdef MM_SCHED_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_jobs_o <= '0;
      perf_busy_o <= '0;
    end else begin
      if (done_o && perf_jobs_o != '1) perf_jobs_o <= perf_jobs_o + 32'd1;
      if (busy_o && perf_busy_o != '1) perf_busy_o <= perf_busy_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_sched.sv
module tb_mm_sched;
  localparam int MD = 4;
  localparam int PL = 3;
  localparam int IW = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [2:0]  dim_i = '0;
  logic        mode_i = 1'b0;
  logic [15:0] ovf_i = '0;
  logic        busy_o, pe_start_o, mode_o, res_capture_o, done_o, err_o, ovf_o;
  logic [3:0]  a_rd_en_o, b_rd_en_o;
  logic [7:0]  a_k_o, b_k_o;

  mm_sched #(.DATA_WIDTH(32), .BUS_WIDTH(64), .MAX_DIM(MD), .PE_LAT(PL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .dim_i(dim_i), .mode_i(mode_i), .ovf_i(ovf_i),
    .busy_o(busy_o), .pe_start_o(pe_start_o), .mode_o(mode_o),
    .a_rd_en_o(a_rd_en_o), .a_k_o(a_k_o), .b_rd_en_o(b_rd_en_o), .b_k_o(b_k_o),
    .res_capture_o(res_capture_o), .done_o(done_o), .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ctl = {busy, pe_start, mode, capture, done, err, ovf}; strb = {a_en, a_k, b_en, b_k}
  typedef struct {
    int          cyc;
    logic [6:0]  ctl;
    logic [23:0] strb;
  } snap_t;

  snap_t sb[$];
  int    total = 0;
  int    bad = 0;
  logic  held_ovf = 1'b0;

  // Expected per-cycle view of a job whose first FEED cycle is c0.
  function automatic void push_job(input int c0, input int n, input bit mode,
                                   input logic [15:0] pat, input int abort_t);
    int    cap_t, done_t, last;
    bit    eo, aborted;
    snap_t s;
    logic [3:0] en;
    logic [7:0] k;
    cap_t  = 3*n - 3 + PL;
    done_t = cap_t + 1;
    eo = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        eo = eo | pat[i*MD+j];
    aborted = (abort_t >= 0 && abort_t <= cap_t);
    last = aborted ? abort_t : done_t;
    for (int t = 0; t <= last; t++) begin
      en = '0;
      k  = '0;
      for (int r = 0; r < MD; r++) begin
        if (r < n && t >= r && t <= r + n - 1) begin
          en[r] = 1'b1;
          k[r*IW +: IW] = IW'(t - r);
        end
      end
      s.cyc  = c0 + t;
      s.ctl  = {1'b1, (t <= cap_t), mode, (t == cap_t), (t == done_t), 1'b0,
                (t == done_t) ? eo : 1'b0};
      s.strb = {en, k, en, k};
      sb.push_back(s);
    end
    s.cyc  = c0 + last + 1;
    s.ctl  = {6'b0, aborted ? 1'b0 : eo};
    s.strb = '0;
    sb.push_back(s);
    held_ovf = aborted ? 1'b0 : eo;
  endfunction

  task automatic run_job(input int n, input bit mode, input logic [15:0] pat,
                         input int abort_t, input int stray_t);
    int    c0, done_t, last;
    snap_t s;
    @(negedge clk);
    dim_i = 3'(n); mode_i = mode; ovf_i = pat; start_i = 1'b1; abort_i = 1'b0;
    c0 = cyc + 1;
    if (n < 1 || n > MD) begin
      s.cyc = c0; s.ctl = {5'b0, 1'b1, held_ovf}; s.strb = '0;
      sb.push_back(s);
      @(negedge clk);
      start_i = 1'b0;
      return;
    end
    push_job(c0, n, mode, pat, abort_t);
    done_t = 3*n - 2 + PL;
    last = (abort_t >= 0 && abort_t < done_t) ? abort_t : done_t;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      start_i = (t == stray_t);
      dim_i   = 3'($urandom_range(1, 4));
      mode_i  = 1'($urandom);
      abort_i = (t == abort_t);
    end
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  // Monitor: pop whenever an expected cycle comes due, otherwise the DUT must be quiet.
  always @(negedge clk) begin
    snap_t s;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      s = sb.pop_front();
      total++; bad++;
      $display("FAIL missed_cycle expected cyc=%0d now=%0d", s.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      s = sb.pop_front();
      total++;
      if ({busy_o, pe_start_o, mode_o, res_capture_o, done_o, err_o, ovf_o} !== s.ctl) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%b want=%b", cyc,
                 {busy_o, pe_start_o, mode_o, res_capture_o, done_o, err_o, ovf_o}, s.ctl);
      end
      total++;
      if ({a_rd_en_o, a_k_o, b_rd_en_o, b_k_o} !== s.strb) begin
        bad++;
        $display("FAIL strobes cyc=%0d got=%h want=%h", cyc,
                 {a_rd_en_o, a_k_o, b_rd_en_o, b_k_o}, s.strb);
      end
    end else begin
      total++;
      if ({busy_o, pe_start_o, mode_o, res_capture_o, done_o, err_o,
           a_rd_en_o, b_rd_en_o, a_k_o, b_k_o} !== '0) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d busy=%b pst=%b cap=%b done=%b err=%b aen=%b",
                 cyc, busy_o, pe_start_o, res_capture_o, done_o, err_o, a_rd_en_o);
      end
    end
  end

  task automatic check_all_zero(input string name);
    total++;
    if ({busy_o, pe_start_o, mode_o, res_capture_o, done_o, err_o, ovf_o,
         a_rd_en_o, a_k_o, b_rd_en_o, b_k_o} !== '0) begin
      bad++;
      $display("FAIL %s got busy=%b pst=%b mode=%b aen=%b ak=%h ovf=%b want all zero",
               name, busy_o, pe_start_o, mode_o, a_rd_en_o, a_k_o, ovf_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, ab, st;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_ni = 1'b1;

    // Reset asserted at t=2 of an n=4 job.
    @(negedge clk);
    dim_i = 3'd4; mode_i = 1'b1; ovf_i = '0; start_i = 1'b1;
    c0 = cyc + 1;
    push_job(c0, 4, 1'b1, 16'h0, -1);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_reset_midjob");
    sb.delete();
    held_ovf = 1'b0;
    @(negedge clk); rst_ni = 1'b1;

    run_job(4, 1'b1, 16'h0000, -1, -1);
    run_job(2, 1'b0, 16'h0001, -1, -1);
    run_job(2, 1'b0, 16'h0008, -1, -1);
    run_job(1, 1'b1, 16'h0001, -1, -1);
    run_job(1, 1'b0, 16'hfffe, -1, -1);
    run_job(0, 1'b0, 16'h0000, -1, -1);
    run_job(5, 1'b1, 16'h0000, -1, -1);
    run_job(3, 1'b0, 16'h0000, -1, 6);
    run_job(3, 1'b1, 16'hffff, 4, -1);
    run_job(4, 1'b0, 16'h8000, 10, -1);
    run_job(2, 1'b1, 16'h0020, 7, -1);

    // start together with abort in IDLE must not launch a job.
    @(negedge clk);
    start_i = 1'b1; abort_i = 1'b1; dim_i = 3'd2;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 40; r++) begin
      n  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 7))
                                       : $urandom_range(1, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3*n - 2 + PL) : -1;
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3*n - 2 + PL) : -1;
      run_job(n, 1'($urandom), 16'($urandom), ab, st);
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
